// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST: FSM states and the per-element
// description of the test (direction, operations, read/write backgrounds).
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  localparam int         N_ELEM    = 6;
  localparam logic [2:0] LAST_ELEM = 3'(N_ELEM - 1);

  // Background bit, replicated across the data word by the user.
  localparam logic B0 = 1'b0;
  localparam logic B1 = 1'b1;

  // Bit e of each vector describes March element e (M0 is bit 0).
  localparam logic [N_ELEM-1:0] ELEM_DOWN    = 6'b111000;
  localparam logic [N_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
  localparam logic [N_ELEM-1:0] ELEM_OP0_WR  = 6'b000001;
  localparam logic [N_ELEM-1:0] ELEM_OP1_WR  = 6'b011110;
  localparam logic [N_ELEM-1:0] ELEM_RD_BG   = {B0, B1, B0, B1, B0, B0};
  localparam logic [N_ELEM-1:0] ELEM_WR_BG   = {B0, B0, B1, B0, B1, B0};

  function automatic logic elem_is_write(input logic [2:0] e, input logic op_idx);
    return op_idx ? ELEM_OP1_WR[e] : ELEM_OP0_WR[e];
  endfunction

endpackage

// File: rtl/sram_march_addr_gen.sv
// Loadable up/down address counter; `last` flags the terminal address of the
// current sweep direction (all-ones going up, zero going down).
module sram_march_addr_gen #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_down,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
      down <= load_down;
    end else if (step) begin
      addr <= down ? addr - AW'(1) : addr + AW'(1);
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for a small synchronous SRAM: sequences the six
// elements, compares read data against the background and reports first failure.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [2:0]    fail_elem,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got,
  output logic          sram_rst,
  output logic          sram_wr,
  output logic [DW-1:0] sram_data,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_out
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state;
  logic [2:0]    elem;
  logic          op_idx;
  logic [CW-1:0] wait_cnt;

  logic          gen_load;
  logic          gen_load_down;
  logic          gen_step;
  logic          last;
  logic          wait_last;
  logic          mism;
  logic          adv;
  logic          finish;
  logic          nxt_op;
  logic          nxt_wr;
  logic [2:0]    nxt_elem;
  logic [DW-1:0] exp_data;

  assign sram_rst  = 1'b0;
  assign wait_last = (wait_cnt == CW'(RD_LAT - 1));
  assign exp_data  = {DW{ELEM_RD_BG[elem]}};
  assign mism      = (state == ST_RD_WAIT) && wait_last && (sram_out != exp_data);
  // adv: the current op is complete (or a test is being launched) and the
  // sequencer moves on to the next op, address or element.
  assign adv = ((state == ST_IDLE) && start) || (state == ST_WR) ||
               ((state == ST_RD_WAIT) && wait_last && !mism);

  sram_march_addr_gen #(.AW(AW)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (gen_load),
    .load_down (gen_load_down),
    .step      (gen_step),
    .addr      (sram_addr),
    .last      (last)
  );

  always_comb begin
    nxt_elem      = elem;
    nxt_op        = 1'b0;
    finish        = 1'b0;
    gen_load      = 1'b0;
    gen_load_down = 1'b0;
    gen_step      = 1'b0;
    if (state == ST_IDLE) begin
      nxt_elem      = '0;
      gen_load      = start;
      gen_load_down = ELEM_DOWN[0];
    end else if (adv) begin
      if (!op_idx && ELEM_TWO_OPS[elem]) begin
        nxt_op = 1'b1;
      end else if (!last) begin
        gen_step = 1'b1;
      end else if (elem == LAST_ELEM) begin
        finish = 1'b1;
      end else begin
        nxt_elem      = elem + 3'd1;
        gen_load      = 1'b1;
        gen_load_down = ELEM_DOWN[nxt_elem];
      end
    end
    nxt_wr = elem_is_write(nxt_elem, nxt_op);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      elem      <= '0;
      op_idx    <= 1'b0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      sram_wr   <= 1'b0;
      sram_data <= '0;
    end else begin
      done <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        busy      <= 1'b1;
        pass      <= 1'b0;
        fail_elem <= '0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end
      if (mism) begin
        fail_elem <= elem;
        fail_addr <= sram_addr;
        fail_exp  <= exp_data;
        fail_got  <= sram_out;
        pass      <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        state     <= ST_DONE;
      end else if (adv && finish) begin
        pass    <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
        sram_wr <= 1'b0;
        state   <= ST_DONE;
      end else if (adv) begin
        elem      <= nxt_elem;
        op_idx    <= nxt_op;
        state     <= nxt_wr ? ST_WR : ST_RD;
        sram_wr   <= nxt_wr;
        sram_data <= {DW{ELEM_WR_BG[nxt_elem]}};
      end else begin
        case (state)
          ST_RD: begin
            state    <= ST_RD_WAIT;
            wait_cnt <= '0;
          end
          ST_RD_WAIT: wait_cnt <= wait_cnt + CW'(1);
          ST_DONE:    state    <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM with a single stuck-at bit and a
// March C- reference model that predicts the bus trace and the verdict.
module tb_sram_march_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass, sram_rst, sram_wr;
  logic [2:0] fail_elem;
  logic [3:0] fail_addr, fail_exp, fail_got, sram_data, sram_addr;
  logic [3:0] rdata;

  int total = 0;
  int bad   = 0;

  sram_march_bist #(.AW(4), .DW(4), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_elem (fail_elem),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got),
    .sram_rst  (sram_rst),
    .sram_wr   (sram_wr),
    .sram_data (sram_data),
    .sram_addr (sram_addr),
    .sram_out  (rdata)
  );

  always #5 clk = ~clk;

  // SRAM with registered output and one optional stuck-at cell bit
  logic [3:0] mem [16];
  bit         f_on  = 1'b0;
  int         f_addr = 0;
  int         f_bit  = 0;
  bit         f_sa1  = 1'b0;

  function automatic logic [3:0] faulty(input logic [3:0] a, input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (f_on && int'(a) == f_addr) r[f_bit] = f_sa1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_wr) mem[sram_addr] <= sram_data;
    rdata <= faulty(sram_addr, mem[sram_addr]);
  end

  // Per-cycle trace of the SRAM bus while busy: {wr, addr, wr ? data : 0}
  logic [8:0] mon_q[$];
  int         mon_done  = 0;
  int         mon_stray = 0;

  always @(posedge clk) begin
    #1;
    if (busy) mon_q.push_back({sram_wr, sram_addr, sram_wr ? sram_data : 4'h0});
    if (done) mon_done++;
    if (sram_wr && !busy) mon_stray++;
  end

  // Reference model: March C- written as op strings, run on an array memory.
  string      march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  logic [8:0] m_q[$];
  bit         m_pass;
  logic [2:0] m_elem;
  logic [3:0] m_addr, m_exp, m_got;

  task automatic model_run(input bit fon, input int fa, input int fb, input bit fs);
    logic [3:0] mm [16];
    logic [3:0] v, bgv;
    string      ops;
    int         a;
    m_q.delete();
    m_pass = 1'b1; m_elem = '0; m_addr = '0; m_exp = '0; m_got = '0;
    for (int e = 0; e < 6; e++) begin
      ops = march[e];
      for (int i = 0; i < 16; i++) begin
        a = (e >= 3) ? 15 - i : i;
        for (int k = 0; k < ops.len(); k += 2) begin
          bgv = (ops[k+1] == "1") ? 4'hF : 4'h0;
          if (ops[k] == "w") begin
            mm[a] = bgv;
            m_q.push_back({1'b1, 4'(a), bgv});
          end else begin
            v = mm[a];
            if (fon && a == fa) v[fb] = fs;
            m_q.push_back({1'b0, 4'(a), 4'h0});
            m_q.push_back({1'b0, 4'(a), 4'h0});
            if (v !== bgv) begin
              m_pass = 1'b0; m_elem = 3'(e); m_addr = 4'(a); m_exp = bgv; m_got = v;
              return;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/busy"}, 32'(busy), 0);
    chk({tag, "/done"}, 32'(done), 0);
    chk({tag, "/pass"}, 32'(pass), 0);
    chk({tag, "/fail"}, {17'd0, fail_elem, fail_addr, fail_exp, fail_got}, 0);
    chk({tag, "/sram_bus"}, {22'd0, sram_wr, sram_data, sram_addr, sram_rst}, 0);
  endtask

  task automatic run_case(input string tag, input bit fon, input int fa, input int fb,
                          input bit fs, input int rep1, input int rep2);
    int cyc;
    int ndiff;
    model_run(fon, fa, fb, fs);
    @(negedge clk);
    f_on = fon; f_addr = fa; f_bit = fb; f_sa1 = fs;
    mon_q.delete(); mon_done = 0; mon_stray = 0;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == rep1) || (cyc == rep2);
    end while (mon_done == 0 && cyc < 1000);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "/done_count"}, 32'(mon_done), 1);
    chk({tag, "/busy_after"}, 32'(busy), 0);
    chk({tag, "/pass"}, 32'(pass), 32'(m_pass));
    chk({tag, "/fail_elem"}, 32'(fail_elem), 32'(m_elem));
    chk({tag, "/fail_addr"}, 32'(fail_addr), 32'(m_addr));
    chk({tag, "/fail_exp"}, 32'(fail_exp), 32'(m_exp));
    chk({tag, "/fail_got"}, 32'(fail_got), 32'(m_got));
    chk({tag, "/busy_cycles"}, 32'(mon_q.size()), 32'(m_q.size()));
    ndiff = 0;
    for (int i = 0; i < m_q.size() && i < mon_q.size(); i++)
      if (mon_q[i] !== m_q[i]) ndiff++;
    chk({tag, "/bus_trace_diffs"}, 32'(ndiff), 0);
    chk({tag, "/wr_outside_busy"}, 32'(mon_stray), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_n;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run with stray starts at cycles 3, 100 and during DONE
    run_case("clean", 0, 0, 0, 0, 3, 241);
    chk("clean/busy_240", 32'(mon_q.size()), 240);
    wr_n = 0;
    foreach (mon_q[i]) if (mon_q[i][8]) wr_n++;
    chk("clean/wr_80", 32'(wr_n), 80);
    run_case("rep100", 0, 0, 0, 0, 100, 0);
    run_case("second", 0, 0, 0, 0, 0, 0);

    run_case("sa1_a5_b2", 1, 5, 2, 1, 0, 0);
    chk("sa1_a5_b2/elem", 32'(fail_elem), 1);
    chk("sa1_a5_b2/got", 32'(fail_got), 32'h4);
    run_case("sa0_a10_b0", 1, 10, 0, 0, 0, 0);
    chk("sa0_a10_b0/elem", 32'(fail_elem), 2);
    chk("sa0_a10_b0/got", 32'(fail_got), 32'hE);

    for (int n = 0; n < 6; n++)
      run_case($sformatf("rand%0d", n), 1, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(2, 239)), 0);
    run_case("rand_clean", 0, 0, 0, 0, int'($urandom_range(2, 239)), 0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    f_on = 1'b0;
    mon_done = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (118) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_rst/no_done", 32'(mon_done), 0);
    chk("mid_rst/idle_busy", 32'(busy), 0);
    run_case("after_rst", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of the 16x4 SRAM (SRAM4x16) and owns its clk/rst/wr/data/addr inputs while in test.
- Runs a March C- sequence over all addresses, compares `out` against expected background data, and reports pass/fail with the first failing location.
- Replaces ad-hoc random write/read benches as the on-chip memory check; outside test, the mux upstream of the SRAM gives control back to the functional path.

Parameters:
- AW, 4, SRAM address width (depth = 2**AW).
- DW, 4, SRAM data width.
- RD_LAT, 1, cycles from the sampling edge of a read request to valid `sram_out` (1 = registered SRAM output).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the test ends.
- done  out  1  one-cycle pulse when the test finishes, whether it passed or aborted.
- pass  out  1  result; valid from done until the next accepted start.
- fail_elem  out  3  March element index (0-5) of the first mismatch.
- fail_addr  out  AW  address of the first mismatch.
- fail_exp  out  DW  expected read data at the mismatch.
- fail_got  out  DW  actual read data at the mismatch.
- sram_rst  out  1  SRAM reset; tied 0 (M0 initialises memory).
- sram_wr  out  1  SRAM write enable.
- sram_data  out  DW  SRAM write data.
- sram_addr  out  AW  SRAM address.
- sram_out  in  DW  SRAM read data.

Behaviour:
- Reset (async, rst=1) sets: state=IDLE, busy=0, done=0, pass=0, all fail_* =0, sram_wr=0, sram_data=0, sram_addr=0.
- March C- elements (B0 = all-0, B1 = all-1):
  - M0 up: w0
  - M1 up: r0,w1
  - M2 up: r1,w0
  - M3 down: r0,w1
  - M4 down: r1,w0
  - M5 down: r0
- Up elements run addresses 0..15; down elements run 15..0.
- States: IDLE, WR, RD, RD_WAIT, DONE.
- IDLE: on start=1, go to the first op of M0 at addr 0; busy=1 from the next cycle.
- WR: drive sram_wr=1 for exactly one cycle with sram_addr and the background on sram_data.
- RD: drive sram_wr=0 and sram_addr for one cycle, then hold sram_addr for RD_LAT cycles in RD_WAIT. Compare sram_out to expected in the last RD_WAIT cycle.
- Cycle counts per address: write op = 1 cycle; read op = 1+RD_LAT cycles.
- Within an element, ops run in order at one address, then the address advances with no idle cycle. The last address of an element moves straight to the first op of the next element.
- At RD_LAT=1, total busy cycles = 16 + 4·(16·3) + 16·2 = 240.
- Mismatch: latch fail_elem/fail_addr/fail_exp/fail_got on that cycle, skip remaining ops, go to DONE; pass=0.
- DONE: one cycle. done=1, busy=0, pass=1 if no mismatch occurred. Then return to IDLE.
- start while busy or in DONE: ignored, no effect.
- Reset mid-test: immediate abort to the reset values. SRAM contents are undefined afterwards; a new start reruns from M0.
- Address counter wraps in AW bits; end of element is detected by terminal count (15 going up, 0 going down), never by overflow.
- sram_wr is never high outside WR.

Decomposition:
- Shared package sram_bist_pkg:
  - state enum;
  - element count (6);
  - per-element constants: direction, op list, read background, write background;
  - B0/B1 constants.
- Sub-module sram_march_addr_gen: loadable up/down AW-bit counter with `last` flag. The FSM and comparator stay in the top.

Test Plan:
- Fault-free SRAM, RD_LAT=1, start pulse -> busy high for 240 cycles, done pulse once, pass=1, fail_* =0.
- Bit 2 at addr 5 stuck-at-1 -> abort in M1 reading addr 5: fail_elem=1, fail_addr=0101, fail_exp=0000, fail_got=0100, pass=0.
- Bit 0 at addr 10 stuck-at-0 -> abort in M2: fail_elem=2, fail_addr=1010, fail_exp=1111, fail_got=1110, pass=0.
- start re-pulsed at cycles 3 and 100 of a fault-free run -> ignored, still 240 busy cycles and a single done. A second start after done -> identical second run, pass=1.
- rst asserted at cycle 120, held 2 cycles, released -> all outputs at reset values asynchronously, no done. Next start completes with pass=1.
- Monitor for the whole run -> sram_wr high exactly 16+4·16=80 cycles, addr order 0..15 for M0-M2 and 15..0 for M3-M5.
